// File: rtl/pong_pkg.sv
// Shared encodings and BCD helpers for the Pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned SCORE_W   = 2 * DIGIT_W;
    localparam int unsigned MAX_SCORE = 99;

    // Binary (0..99) to packed two-digit BCD {tens, ones}.
    function automatic logic [SCORE_W-1:0] to_bcd(input int unsigned n);
        return {DIGIT_W'(n / 10), DIGIT_W'(n % 10)};
    endfunction

    // Two-digit BCD increment that saturates at MAX_SCORE.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = v[SCORE_W-1:DIGIT_W];
        ones = v[DIGIT_W-1:0];
        if (v == to_bcd(MAX_SCORE)) return v;
        if (ones == DIGIT_W'(9)) return {tens + DIGIT_W'(1), DIGIT_W'(0)};
        return {tens, ones + DIGIT_W'(1)};
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score register: sync clear, increment enable, saturates at 99.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] value
);

    // Score register; clear wins over increment.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= bcd_inc(value);
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-control FSM: start edge detect, serve countdown, play/pause, scoring and game over.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned PW          = $clog2(N_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start_btn,
    input  logic                         game_tick,
    input  logic                         point_valid,
    input  logic [PW-1:0]                point_player,
    output logic                         run,
    output logic                         serve,
    output logic [PW-1:0]                serve_player,
    output logic [2:0]                   state,
    output logic [SCORE_W*N_PLAYERS-1:0] score_bcd,
    output logic                         game_over,
    output logic [PW-1:0]                winner
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0]   DELAY   = CNT_W'(SERVE_DELAY);
    localparam logic [SCORE_W-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    state_t             st;
    logic               start_q;
    logic               start_ev;
    logic [CNT_W-1:0]   cnt;
    logic               pp_ok;
    logic               take_point;
    logic               win;
    logic               clear_scores;
    logic [SCORE_W-1:0] cur;
    logic [PW-1:0]      next_sp;
    logic [N_PLAYERS-1:0] inc;
    logic [SCORE_W-1:0] scores [N_PLAYERS];

    assign start_ev     = start_btn & ~start_q;
    assign pp_ok        = (32'(point_player) < N_PLAYERS);
    assign take_point   = (st == ST_PLAY) && point_valid && pp_ok;
    assign clear_scores = (st == ST_IDLE) && start_ev;
    assign win          = take_point && (bcd_inc(cur) == WIN_BCD);
    assign next_sp      = (32'(point_player) == N_PLAYERS - 1) ? '0 : point_player + PW'(1);
    assign state        = st;

    // Select the scoring player's current score and route its increment enable.
    always_comb begin
        cur = '0;
        inc = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (point_player == PW'(i)) begin
                cur    = scores[i];
                inc[i] = take_point;
            end
        end
    end

    // One BCD score counter per player, flattened onto score_bcd.
    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        bcd2_counter u_score (
            .clk   (clk),
            .clr   (clr),
            .clear (clear_scores),
            .inc   (inc[g]),
            .value (scores[g])
        );
        assign score_bcd[g*SCORE_W +: SCORE_W] = scores[g];
    end

    // Match FSM with registered outputs and the serve countdown.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st           <= ST_IDLE;
            start_q      <= 1'b0;
            cnt          <= '0;
            run          <= 1'b0;
            serve        <= 1'b0;
            serve_player <= '0;
            game_over    <= 1'b0;
            winner       <= '0;
        end else begin
            start_q <= start_btn;
            serve   <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (start_ev) begin
                        winner <= '0;
                        cnt    <= DELAY;
                        st     <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (game_tick) begin
                        if (cnt <= CNT_W'(1)) begin
                            cnt   <= '0;
                            serve <= 1'b1;
                            run   <= 1'b1;
                            st    <= ST_PLAY;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // A point outranks a pause request in the same cycle.
                    if (take_point) begin
                        run <= 1'b0;
                        if (win) begin
                            winner    <= point_player;
                            game_over <= 1'b1;
                            st        <= ST_OVER;
                        end else begin
                            serve_player <= next_sp;
                            cnt          <= DELAY;
                            st           <= ST_SERVE;
                        end
                    end else if (start_ev) begin
                        run <= 1'b0;
                        st  <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start_ev) begin
                        run <= 1'b1;
                        st  <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start_ev) begin
                        game_over <= 1'b0;
                        st        <= ST_IDLE;
                    end
                end
                default: begin
                    run       <= 1'b0;
                    game_over <= 1'b0;
                    st        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: a 2-player instance and a 3-player instance.
module tb_pong_match_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 2 players, win at 11, serve after 3 ticks.
    logic        a_clr = 1'b1, a_start = 1'b0, a_tick = 1'b0, a_pv = 1'b0;
    logic        a_pp = 1'b0;
    logic        a_run, a_serve, a_sp, a_go, a_win;
    logic [2:0]  a_state;
    logic [15:0] a_score;

    // Instance B: 3 players, win at 11, serve after 2 ticks.
    logic        b_clr = 1'b1, b_start = 1'b0, b_tick = 1'b0, b_pv = 1'b0;
    logic [1:0]  b_pp = 2'd0;
    logic        b_run, b_serve, b_go;
    logic [1:0]  b_sp, b_win;
    logic [2:0]  b_state;
    logic [23:0] b_score;

    pong_match_ctrl #(.N_PLAYERS(2), .WIN_SCORE(11), .SERVE_DELAY(3)) dut_a (
        .clk(clk), .clr(a_clr), .start_btn(a_start), .game_tick(a_tick),
        .point_valid(a_pv), .point_player(a_pp), .run(a_run), .serve(a_serve),
        .serve_player(a_sp), .state(a_state), .score_bcd(a_score),
        .game_over(a_go), .winner(a_win)
    );

    pong_match_ctrl #(.N_PLAYERS(3), .WIN_SCORE(11), .SERVE_DELAY(2)) dut_b (
        .clk(clk), .clr(b_clr), .start_btn(b_start), .game_tick(b_tick),
        .point_valid(b_pv), .point_player(b_pp), .run(b_run), .serve(b_serve),
        .serve_player(b_sp), .state(b_state), .score_bcd(b_score),
        .game_over(b_go), .winner(b_win)
    );

    localparam logic [2:0] IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSED = 3'd3, OVER = 3'd4;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs/outputs are handled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_press();
        a_start = 1'b1; cyc(); a_start = 1'b0; cyc();
    endtask

    task automatic a_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            a_tick = 1'b1; cyc(); a_tick = 1'b0;
        end
    endtask

    task automatic a_point(input logic p);
        a_pv = 1'b1; a_pp = p; cyc(); a_pv = 1'b0;
    endtask

    task automatic b_point(input logic [1:0] p);
        b_pv = 1'b1; b_pp = p; cyc(); b_pv = 1'b0;
    endtask

    task automatic b_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            b_tick = 1'b1; cyc(); b_tick = 1'b0;
        end
    endtask

    initial begin
        logic [2:0] prev;
        int trans;

        #12;
        a_clr = 1'b0;
        b_clr = 1'b0;
        cyc();

        // Reset values
        check("a_rst_state", 32'(a_state), 32'(IDLE));
        check("a_rst_run",   32'(a_run),   0);
        check("a_rst_serve", 32'(a_serve), 0);
        check("a_rst_sp",    32'(a_sp),    0);
        check("a_rst_score", 32'(a_score), 0);
        check("a_rst_go",    32'(a_go),    0);
        check("a_rst_win",   32'(a_win),   0);

        // Holding start for 100 cycles gives exactly one IDLE->SERVE step
        trans = 0;
        prev = a_state;
        a_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (a_state != prev) trans++;
            prev = a_state;
        end
        a_start = 1'b0;
        cyc();
        check("a_hold_trans", 32'(trans), 1);
        check("a_hold_state", 32'(a_state), 32'(SERVE));

        // Serve countdown of 3 ticks
        a_ticks(1);
        check("a_tick1_serve", 32'(a_serve), 0);
        check("a_tick1_state", 32'(a_state), 32'(SERVE));
        a_ticks(1);
        check("a_tick2_serve", 32'(a_serve), 0);
        a_ticks(1);
        check("a_tick3_serve", 32'(a_serve), 1);
        check("a_tick3_state", 32'(a_state), 32'(PLAY));
        check("a_tick3_run",   32'(a_run),   1);
        cyc();
        check("a_serve_pulse", 32'(a_serve), 0);
        check("a_play_run",    32'(a_run),   1);

        // Player 1 scores 10 times, re-serving after each
        for (int k = 0; k < 10; k++) begin
            a_point(1'b1);
            check("a_p1_state", 32'(a_state), 32'(SERVE));
            check("a_p1_sp",    32'(a_sp),    0);
            check("a_p1_run",   32'(a_run),   0);
            a_ticks(3);
            check("a_p1_play",  32'(a_state), 32'(PLAY));
        end
        check("a_p1_score10", 32'(a_score), 32'h1000);

        // Pause freezes ticks and points
        a_press();
        check("a_pause_state", 32'(a_state), 32'(PAUSED));
        check("a_pause_run",   32'(a_run),   0);
        a_ticks(4);
        a_point(1'b0);
        cyc();
        check("a_pause_hold",  32'(a_state), 32'(PAUSED));
        check("a_pause_score", 32'(a_score), 32'h1000);
        a_press();
        check("a_resume_state", 32'(a_state), 32'(PLAY));
        check("a_resume_run",   32'(a_run),   1);
        check("a_resume_serve", 32'(a_serve), 0);

        // Point and pause request in the same cycle: point wins
        a_pv = 1'b1; a_pp = 1'b0; a_start = 1'b1;
        cyc();
        a_pv = 1'b0; a_start = 1'b0;
        check("a_both_state", 32'(a_state), 32'(SERVE));
        check("a_both_score", 32'(a_score), 32'h1001);
        check("a_both_sp",    32'(a_sp),    1);
        a_ticks(3);
        check("a_both_play",  32'(a_state), 32'(PLAY));

        // Player 0 climbs from 1 to 11
        for (int k = 0; k < 9; k++) begin
            a_point(1'b0);
            check("a_p0_state", 32'(a_state), 32'(SERVE));
            a_ticks(3);
        end
        check("a_p0_score10", 32'(a_score), 32'h1010);
        a_point(1'b0);
        check("a_win_state", 32'(a_state), 32'(OVER));
        check("a_win_go",    32'(a_go),    1);
        check("a_win_who",   32'(a_win),   0);
        check("a_win_score", 32'(a_score), 32'h1011);
        check("a_win_run",   32'(a_run),   0);

        // Points are ignored once the match is over
        a_point(1'b1);
        check("a_over_ignore", 32'(a_score), 32'h1011);
        check("a_over_state",  32'(a_state), 32'(OVER));

        // Start returns to IDLE with scores displayed, next start clears
        a_press();
        check("a_idle_state", 32'(a_state), 32'(IDLE));
        check("a_idle_score", 32'(a_score), 32'h1011);
        check("a_idle_go",    32'(a_go),    0);
        a_press();
        check("a_restart_state", 32'(a_state), 32'(SERVE));
        check("a_restart_score", 32'(a_score), 0);

        // Instance B: 3-player behaviour and mid-match reset
        b_start = 1'b1; cyc(); b_start = 1'b0; cyc();
        check("b_start_state", 32'(b_state), 32'(SERVE));
        b_ticks(2);
        check("b_serve_pulse", 32'(b_serve), 1);
        check("b_play_state",  32'(b_state), 32'(PLAY));
        b_point(2'd3);
        check("b_bad_player_state", 32'(b_state), 32'(PLAY));
        check("b_bad_player_score", 32'(b_score), 0);
        b_point(2'd2);
        check("b_p2_state", 32'(b_state), 32'(SERVE));
        check("b_p2_sp",    32'(b_sp),    0);
        check("b_p2_score", 32'(b_score), 32'h010000);
        b_ticks(2);
        b_point(2'd0);
        check("b_p0_sp",    32'(b_sp),    1);
        check("b_p0_score", 32'(b_score), 32'h010001);
        b_ticks(1);
        check("b_mid_serve", 32'(b_state), 32'(SERVE));

        // Asynchronous clear between edges
        #3;
        b_clr = 1'b1;
        #1;
        check("b_clr_state", 32'(b_state), 32'(IDLE));
        check("b_clr_score", 32'(b_score), 0);
        check("b_clr_sp",    32'(b_sp),    0);
        check("b_clr_run",   32'(b_run),   0);
        check("b_clr_serve", 32'(b_serve), 0);
        check("b_clr_go",    32'(b_go),    0);
        check("b_clr_win",   32'(b_win),   0);
        #2;
        b_clr = 1'b0;
        cyc();
        b_ticks(3);
        check("b_after_clr_state", 32'(b_state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
